// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column drive, frame debounce, press/release events.
// Optional auto-repeat of a held key is built when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV     = 8192,
    parameter int DEBOUNCE     = 3,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8,
    localparam int CODE_W      = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ROWS-1:0]   rows,
    output logic [COLS-1:0]   columns,
    output logic              evt_valid,
    output logic              evt_press,
    output logic              evt_repeat,
    output logic [CODE_W-1:0] evt_code,
    output logic              key_down,
    output logic [CODE_W-1:0] key_code
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        R_NONE   = 2'd0,
        R_SINGLE = 2'd1,
        R_MULTI  = 2'd2
    } res_t;

    typedef enum logic {
        EV_IDLE,
        EV_PEND
    } ev_state_t;

    logic [1:0]        rst_q;
    logic              rst_i;
    logic [ROWS-1:0]   rows_m;
    logic [ROWS-1:0]   rows_s;
    logic [DIV_W-1:0]  div;
    logic [COL_W-1:0]  col;
    logic              tick;
    logic              frame_end;

    logic [1:0]        slot_n;
    logic [ROW_W-1:0]  slot_row;
    logic [CODE_W-1:0] slot_code;

    res_t              acc_kind;
    logic [CODE_W-1:0] acc_code;
    res_t              frm_kind;
    logic [CODE_W-1:0] frm_code;
    res_t              prv_kind;
    logic [CODE_W-1:0] prv_code;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic              same;
    logic              commit;

    ev_state_t         ev_state;
    ev_state_t         ev_next;
    logic [CODE_W-1:0] pend_code;
    logic [CODE_W-1:0] pend_n;
    res_t              com_kind;
    res_t              com_kind_n;
    logic [CODE_W-1:0] com_code;
    logic [CODE_W-1:0] com_code_n;
    logic              valid_n;
    logic              press_n;
    logic [CODE_W-1:0] ecode_n;
    logic              kd_n;
    logic [CODE_W-1:0] kc_n;

    // Reset asserts asynchronously, releases two clocks later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_q <= '0;
        else          rst_q <= {rst_q[0], 1'b1};
    end

    assign rst_i = rst_q[1];

    always_ff @(posedge clock or negedge rst_i) begin
        if (!rst_i) begin
            rows_m <= '1;
            rows_s <= '1;
        end else begin
            rows_m <= rows;
            rows_s <= rows_m;
        end
    end

    assign tick      = (div == DIV_W'(SCAN_DIV - 1));
    assign frame_end = tick && (col == COL_W'(COLS - 1));
    assign columns   = ~(COLS'(1) << col);

    always_comb begin
        slot_n   = 2'd0;
        slot_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (!rows_s[r]) begin
                if (slot_n == 2'd0) slot_row = ROW_W'(r);
                slot_n = (slot_n == 2'd0) ? 2'd1 : 2'd2;
            end
        end
    end

    assign slot_code = CODE_W'(int'(col) * ROWS + int'(slot_row));

    // Fold this slot into the frame result; code stays 0 unless SINGLE.
    always_comb begin
        frm_kind = acc_kind;
        frm_code = acc_code;
        if (slot_n == 2'd2 || (slot_n == 2'd1 && acc_kind != R_NONE)) begin
            frm_kind = R_MULTI;
            frm_code = '0;
        end else if (slot_n == 2'd1) begin
            frm_kind = R_SINGLE;
            frm_code = slot_code;
        end
    end

    assign same   = (frm_kind == prv_kind) && (frm_code == prv_code);
    assign cnt_n  = !same ? CNT_W'(1)
                  : (cnt == CNT_W'(DEBOUNCE)) ? cnt : cnt + 1'b1;
    assign commit = frame_end && (cnt_n == CNT_W'(DEBOUNCE))
                  && (frm_kind != com_kind || frm_code != com_code);

    always_ff @(posedge clock or negedge rst_i) begin
        if (!rst_i) begin
            div      <= '0;
            col      <= '0;
            acc_kind <= R_NONE;
            acc_code <= '0;
            prv_kind <= R_NONE;
            prv_code <= '0;
            cnt      <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                col <= (col == COL_W'(COLS - 1)) ? '0 : col + 1'b1;
                if (frame_end) begin
                    acc_kind <= R_NONE;
                    acc_code <= '0;
                    prv_kind <= frm_kind;
                    prv_code <= frm_code;
                    cnt      <= cnt_n;
                end else begin
                    acc_kind <= frm_kind;
                    acc_code <= frm_code;
                end
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DELAY + 1) + 1;

    logic             rep_q;
    logic             rep_n;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rcnt_n;
`endif

    always_comb begin
        ev_next    = EV_IDLE;
        pend_n     = pend_code;
        com_kind_n = com_kind;
        com_code_n = com_code;
        valid_n    = 1'b0;
        press_n    = evt_press;
        ecode_n    = evt_code;
        kd_n       = key_down;
        kc_n       = key_code;
`ifdef KEYPAD_REPEAT_EN
        rep_n      = rep_q;
        rcnt_n     = rep_cnt;
`endif
        unique case (ev_state)
            EV_PEND: begin
                valid_n = 1'b1;
                press_n = 1'b1;
                ecode_n = pend_code;
                kd_n    = 1'b1;
                kc_n    = pend_code;
`ifdef KEYPAD_REPEAT_EN
                rep_n   = 1'b0;
`endif
            end
            default: ;
        endcase
        if (commit) begin
            com_kind_n = frm_kind;
            com_code_n = frm_code;
`ifdef KEYPAD_REPEAT_EN
            rcnt_n     = '0;
            rep_n      = 1'b0;
`endif
            case (com_kind)
                // A key-to-key change releases now and presses next cycle.
                R_SINGLE: begin
                    valid_n = 1'b1;
                    press_n = 1'b0;
                    ecode_n = com_code;
                    kd_n    = 1'b0;
                    kc_n    = '0;
                    if (frm_kind == R_SINGLE) begin
                        ev_next = EV_PEND;
                        pend_n  = frm_code;
                    end
                end
                default: begin
                    if (frm_kind == R_SINGLE) begin
                        valid_n = 1'b1;
                        press_n = 1'b1;
                        ecode_n = frm_code;
                        kd_n    = 1'b1;
                        kc_n    = frm_code;
                    end
                end
            endcase
        end
`ifdef KEYPAD_REPEAT_EN
        else if (frame_end && com_kind == R_SINGLE) begin
            if (rep_cnt + 1'b1 == REP_W'(REPEAT_DELAY)) begin
                valid_n = 1'b1;
                press_n = 1'b1;
                rep_n   = 1'b1;
                ecode_n = com_code;
                rcnt_n  = REP_W'(REPEAT_DELAY - REPEAT_RATE);
            end else begin
                rcnt_n  = rep_cnt + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge rst_i) begin
        if (!rst_i) begin
            ev_state  <= EV_IDLE;
            pend_code <= '0;
            com_kind  <= R_NONE;
            com_code  <= '0;
            evt_valid <= 1'b0;
            evt_press <= 1'b0;
            evt_code  <= '0;
            key_down  <= 1'b0;
            key_code  <= '0;
        end else begin
            ev_state  <= ev_next;
            pend_code <= pend_n;
            com_kind  <= com_kind_n;
            com_code  <= com_code_n;
            evt_valid <= valid_n;
            evt_press <= press_n;
            evt_code  <= ecode_n;
            key_down  <= kd_n;
            key_code  <= kc_n;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clock or negedge rst_i) begin
        if (!rst_i) begin
            rep_q   <= 1'b0;
            rep_cnt <= '0;
        end else begin
            rep_q   <= rep_n;
            rep_cnt <= rcnt_n;
        end
    end

    assign evt_repeat = rep_q;
`else
    assign evt_repeat = 1'b0;
`endif

endmodule
